regfile_burst_reader: RTL and testbench

- Read-side master for the 8x8 register file: walks a contiguous, wrapping range of entries by driving the file's rsel and sampling its combinational q.
- Delivers each word on a valid/ready stream with its index; pulses done at the end of the burst.
- Sits between the register file and any consumer (display scanner, serial transmitter) so the consumer never handles rsel itself.

---
 rtl/regfile_pkg.sv | 22 ++
 rtl/regfile_burst_reader.sv | 173 +++++++++++++++++
 tb/tb_regfile_burst_reader.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/regfile_pkg.sv
// -----------------------------------------------------------------------------
// regfile_pkg
//   Shared definitions for the 8x8 register file and its burst reader.
//   - WIDTH   : data width of one register-file entry
//   - ADDR_W  : index width (file holds 2**ADDR_W entries)
//   - DEPTH   : number of entries in the register file
//   - state_t : burst reader FSM encoding (IDLE=0, READ=1, HOLD=2, DONE=3)
// -----------------------------------------------------------------------------
package regfile_pkg;

    localparam int WIDTH  = 8;
    localparam int ADDR_W = 3;
    localparam int DEPTH  = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        HOLD = 2'd2,
        DONE = 2'd3
    } state_t;

endpackage

// File: rtl/regfile_burst_reader.sv
// -----------------------------------------------------------------------------
// regfile_burst_reader
//   Read-side master for the register file. Walks a contiguous, wrapping range
//   of entries by driving rsel from a registered pointer, captures the file's
//   combinational read data and presents each word on a valid/ready stream
//   together with the index it came from. done pulses for one cycle at the end
//   of every burst (including an empty one).
//
//   Optional feature (macro READER_CSUM_EN): when defined, csum is the XOR of
//   every word captured during the burst, cleared on burst start and held from
//   the done cycle until the next start. When undefined csum is tied to 0 and
//   no accumulator is built.
//
// Ports:
//   clk        in   system clock, rising edge
//   clr        in   synchronous active-high reset, overrides everything
//   start      in   burst request, only looked at in IDLE
//   base       in   first index of the burst
//   len        in   number of words 0..8 (larger values are clamped to 8)
//   busy       out  FSM is not in IDLE
//   rsel       out  read select to the register file (= pointer)
//   q_in       in   combinational read data from the register file
//   dout       out  captured word
//   dout_idx   out  index dout was read from
//   dout_valid out  dout/dout_idx valid
//   dout_ready in   consumer accepts the current word
//   done       out  one-cycle pulse at burst end
//   csum       out  XOR checksum of the burst, valid while done=1
// -----------------------------------------------------------------------------
module regfile_burst_reader #(
    parameter int WIDTH  = 8,
    parameter int ADDR_W = 3
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              start,
    input  logic [ADDR_W-1:0] base,
    input  logic [ADDR_W:0]   len,
    output logic              busy,
    output logic [ADDR_W-1:0] rsel,
    input  logic [WIDTH-1:0]  q_in,
    output logic [WIDTH-1:0]  dout,
    output logic [ADDR_W-1:0] dout_idx,
    output logic              dout_valid,
    input  logic              dout_ready,
    output logic              done,
    output logic [WIDTH-1:0]  csum
);

    localparam int CNT_W = ADDR_W + 1;
    // Longest burst is one full lap of the file.
    localparam logic [CNT_W-1:0] LEN_MAX = CNT_W'(1 << ADDR_W);

    regfile_pkg::state_t state_reg, state_next;

    logic [ADDR_W-1:0] ptr_reg,   ptr_next;
    logic [CNT_W-1:0]  cnt_reg,   cnt_next;
    logic [WIDTH-1:0]  dout_reg,  dout_next;
    logic [ADDR_W-1:0] idx_reg,   idx_next;
    logic              valid_reg, valid_next;

    // -------------------------------------------------------------------------
    // State and datapath registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (clr) begin
            state_reg <= regfile_pkg::IDLE;
            ptr_reg   <= '0;
            cnt_reg   <= '0;
            dout_reg  <= '0;
            idx_reg   <= '0;
            valid_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            ptr_reg   <= ptr_next;
            cnt_reg   <= cnt_next;
            dout_reg  <= dout_next;
            idx_reg   <= idx_next;
            valid_reg <= valid_next;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state and datapath update
    // -------------------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        ptr_next   = ptr_reg;
        cnt_next   = cnt_reg;
        dout_next  = dout_reg;
        idx_next   = idx_reg;
        valid_next = valid_reg;

        case (state_reg)
            regfile_pkg::IDLE: begin
                if (start) begin
                    if (len == '0) begin
                        // Empty burst: straight to the done pulse.
                        state_next = regfile_pkg::DONE;
                    end else begin
                        ptr_next   = base;
                        cnt_next   = (len > LEN_MAX) ? LEN_MAX : len;
                        state_next = regfile_pkg::READ;
                    end
                end
            end

            regfile_pkg::READ: begin
                // rsel has been stable on ptr for a full cycle, so q_in is
                // the settled value of the selected entry.
                dout_next  = q_in;
                idx_next   = ptr_reg;
                valid_next = 1'b1;
                state_next = regfile_pkg::HOLD;
            end

            regfile_pkg::HOLD: begin
                if (dout_ready) begin
                    valid_next = 1'b0;
                    if (cnt_reg == CNT_W'(1)) begin
                        state_next = regfile_pkg::DONE;
                    end else begin
                        // Natural ADDR_W-bit overflow gives the wrap to 0.
                        ptr_next   = ptr_reg + ADDR_W'(1);
                        cnt_next   = cnt_reg - CNT_W'(1);
                        state_next = regfile_pkg::READ;
                    end
                end
            end

            regfile_pkg::DONE: begin
                state_next = regfile_pkg::IDLE;
            end

            default: begin
                state_next = regfile_pkg::IDLE;
            end
        endcase
    end

    assign busy       = (state_reg != regfile_pkg::IDLE);
    assign done       = (state_reg == regfile_pkg::DONE);
    assign rsel       = ptr_reg;
    assign dout       = dout_reg;
    assign dout_idx   = idx_reg;
    assign dout_valid = valid_reg;

    // -------------------------------------------------------------------------
    // Optional XOR checksum
    // -------------------------------------------------------------------------
`ifdef READER_CSUM_EN
    logic [WIDTH-1:0] csum_reg;
    logic             csum_clear;

    // Any accepted start (including len=0) begins a new checksum.
    assign csum_clear = (state_reg == regfile_pkg::IDLE) && start;

    always_ff @(posedge clk) begin
        if (clr) begin
            csum_reg <= '0;
        end else if (csum_clear) begin
            csum_reg <= '0;
        end else if (state_reg == regfile_pkg::READ) begin
            csum_reg <= csum_reg ^ q_in;
        end
    end

    assign csum = csum_reg;
`else
    assign csum = '0;
`endif

endmodule

// File: tb/tb_regfile_burst_reader.sv
// -----------------------------------------------------------------------------
// tb_regfile_burst_reader
//   Directed bench for regfile_burst_reader. A behavioural 8x8 register file
//   (array with combinational read on rsel) stands in as the data source.
//   Expected words are pushed into a scoreboard queue when each burst is
//   started and popped whenever the DUT hands a word over (valid && ready).
//   Honours READER_CSUM_EN for the expected checksum.
// -----------------------------------------------------------------------------
module tb_regfile_burst_reader;
    import regfile_pkg::*;

    logic              clk = 1'b0;
    logic              clr;
    logic              start;
    logic [ADDR_W-1:0] base;
    logic [ADDR_W:0]   len;
    logic              busy;
    logic [ADDR_W-1:0] rsel;
    logic [WIDTH-1:0]  q_in;
    logic [WIDTH-1:0]  dout;
    logic [ADDR_W-1:0] dout_idx;
    logic              dout_valid;
    logic              dout_ready;
    logic              done;
    logic [WIDTH-1:0]  csum;

    always #5 clk = ~clk;

    logic [WIDTH-1:0] rf [DEPTH];
    assign q_in = rf[rsel];

    regfile_burst_reader #(
        .WIDTH  (WIDTH),
        .ADDR_W (ADDR_W)
    ) dut (
        .clk        (clk),
        .clr        (clr),
        .start      (start),
        .base       (base),
        .len        (len),
        .busy       (busy),
        .rsel       (rsel),
        .q_in       (q_in),
        .dout       (dout),
        .dout_idx   (dout_idx),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready),
        .done       (done),
        .csum       (csum)
    );

    typedef struct {
        logic [ADDR_W-1:0] idx;
        logic [WIDTH-1:0]  data;
        int                cyc;   // expected handover cycle, -1 = not timed
    } exp_t;

    exp_t             sb[$];
    int               checks       = 0;
    int               errors       = 0;
    int               cyc          = 0;
    int               words_seen   = 0;
    int               words_pushed = 0;
    int               done_seen    = 0;
    int               exp_done_cyc = -1;
    logic [WIDTH-1:0] exp_csum     = '0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Inspect the DUT well after the previous edge, then advance one cycle.
    task automatic tick();
        exp_t e;
        if (dout_valid === 1'b1 && dout_ready === 1'b1) begin
            words_seen++;
            if (sb.size() == 0) begin
                check("spurious_word", words_seen, words_pushed);
            end else begin
                e = sb.pop_front();
                $display("word: idx=%0d data=0x%02h cyc=%0d", dout_idx, dout, cyc);
                check("dout_idx", {29'd0, dout_idx}, {29'd0, e.idx});
                check("dout", {24'd0, dout}, {24'd0, e.data});
                if (e.cyc >= 0) check("word_cycle", cyc, e.cyc);
            end
        end
        if (done === 1'b1) begin
            done_seen++;
            $display("done: csum=0x%02h cyc=%0d", csum, cyc);
            if (exp_done_cyc >= 0) check("done_cycle", cyc, exp_done_cyc);
            check("csum", {24'd0, csum}, {24'd0, exp_csum});
            check("valid_at_done", {31'd0, dout_valid}, 32'd0);
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Compute expected words from the register-file model and queue them.
    task automatic start_burst(input int b, input int l, input bit timed);
        int cyc0;
        int n;
        logic [ADDR_W-1:0] idx;
        exp_t e;
        cyc0 = cyc;
        n = (l > DEPTH) ? DEPTH : l;
        exp_csum = '0;
        for (int i = 0; i < n; i++) begin
            idx    = ADDR_W'(b + i);
            e.idx  = idx;
            e.data = rf[idx];
            e.cyc  = timed ? (cyc0 + 2 + 2 * i) : -1;
            exp_csum ^= rf[idx];
            sb.push_back(e);
            words_pushed++;
        end
`ifndef READER_CSUM_EN
        exp_csum = '0;
`endif
        if (!timed)      exp_done_cyc = -1;
        else if (n == 0) exp_done_cyc = cyc0 + 1;
        else             exp_done_cyc = cyc0 + 2 * n + 1;
        base  = ADDR_W'(b);
        len   = (ADDR_W + 1)'(l);
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Bounded wait for one done pulse, then confirm the burst is fully closed.
    task automatic wait_done(input string tag);
        int d0;
        d0 = done_seen - ((done === 1'b1) ? 0 : 0);
        for (int k = 0; k < 40 && done_seen == d0; k++) tick();
        tick();
        tick();
        check({tag, "_done_pulses"}, done_seen - d0, 1);
        check({tag, "_sb_empty"}, sb.size(), 0);
        check({tag, "_busy_after"}, {31'd0, busy}, 32'd0);
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) rf[i] = '0;
        clr        = 1'b1;
        start      = 1'b0;
        base       = '0;
        len        = '0;
        dout_ready = 1'b1;
        tick();
        tick();
        clr = 1'b0;

        // Reset state
        check("rst_busy",  {31'd0, busy},       32'd0);
        check("rst_valid", {31'd0, dout_valid}, 32'd0);
        check("rst_done",  {31'd0, done},       32'd0);
        check("rst_dout",  {24'd0, dout},       32'd0);
        check("rst_idx",   {29'd0, dout_idx},   32'd0);
        check("rst_rsel",  {29'd0, rsel},       32'd0);
        check("rst_csum",  {24'd0, csum},       32'd0);

        // Basic burst: idx 1..3, ready tied high
        rf[1] = 8'h03;
        rf[3] = 8'h83;
        start_burst(1, 3, 1'b1);
        wait_done("basic");

        // Wrapping burst 6,7,0
        rf[6] = 8'h11;
        rf[7] = 8'h22;
        rf[0] = 8'h44;
        start_burst(6, 3, 1'b1);
        wait_done("wrap");

        // Backpressure: one word held for 6 cycles
        dout_ready = 1'b0;
        start_burst(3, 1, 1'b0);
        tick();
        for (int k = 0; k < 6; k++) begin
            check("bp_valid", {31'd0, dout_valid}, 32'd1);
            check("bp_dout",  {24'd0, dout},       32'h83);
            check("bp_idx",   {29'd0, dout_idx},   32'd3);
            if (k < 5) tick();
        end
        dout_ready   = 1'b1;
        exp_done_cyc = cyc + 1;
        tick();
        wait_done("bp");

        // len=0: done one cycle after start, no words
        begin
            int w0;
            w0 = words_seen;
            start_burst(4, 0, 1'b1);
            wait_done("len0");
            check("len0_words", words_seen - w0, 0);
        end

        // len=12 clamps to 8 words, wrapping from base 5
        rf[2] = 8'h3C;
        rf[4] = 8'h5A;
        rf[5] = 8'hA5;
        begin
            int w0;
            w0 = words_seen;
            start_burst(5, 12, 1'b1);
            wait_done("len12");
            check("len12_words", words_seen - w0, 8);
        end

        // start while busy is ignored
        start_burst(6, 3, 1'b1);
        start = 1'b1;
        base  = 3'd2;
        len   = 4'd5;
        tick();
        tick();
        tick();
        start = 1'b0;
        wait_done("busy_start");

        // clr while holding a word
        dout_ready = 1'b0;
        start_burst(1, 3, 1'b0);
        tick();
        check("pre_clr_valid", {31'd0, dout_valid}, 32'd1);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        check("clr_busy",  {31'd0, busy},       32'd0);
        check("clr_valid", {31'd0, dout_valid}, 32'd0);
        check("clr_dout",  {24'd0, dout},       32'd0);
        words_pushed = words_pushed - sb.size();
        sb.delete();
        dout_ready = 1'b1;
        start_burst(1, 3, 1'b1);
        wait_done("after_clr");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
